// File: rtl/top.sv
// SPI master for the PMOD DA4 (AD5628). A write request sends one 32-bit
// "write and update all DACs" frame. The first request after reset is
// preceded by a one-time internal-reference enable frame.
module top #(
  parameter int SCLK_HALF  = 10,  // system clocks per sclk half-period (2..255)
  parameter int GAP_CYCLES = 20   // minimum cs-high clocks between frames (>= 2)
) (
  input  logic        clk100mhz,
  input  logic        rst,
  output logic        cs,
  output logic        mosi,
  output logic        sclk,
  input  logic        st_wrt,
  input  logic [11:0] data_in,
  output logic        done
);

  // One counter times both sclk half-periods and the inter-frame gap
  localparam int CW = ($clog2(GAP_CYCLES) > 8) ? $clog2(GAP_CYCLES) : 8;
  localparam logic [CW-1:0] HALF_M1 = CW'(SCLK_HALF - 1);
  localparam logic [CW-1:0] GAP_M2  = CW'(GAP_CYCLES - 2);
  localparam logic [31:0]   REF_FRAME = 32'h0800_0001;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_REF,
    S_LOAD_DATA,
    S_SHIFT,
    S_TAIL,
    S_GAP
  } state_t;

  state_t        state_reg, state_next;
  logic [31:0]   shreg_reg, shreg_next;
  logic [11:0]   code_reg, code_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [4:0]    bit_reg, bit_next;
  logic          ref_done_reg, ref_done_next;
  logic          is_ref_reg, is_ref_next;
  logic          cs_reg, cs_next;
  logic          sclk_reg, sclk_next;
  logic          mosi_reg, mosi_next;
  logic          done_reg, done_next;
  logic [31:0]   data_frame;

  assign data_frame = {4'h0, 4'b0011, 4'b1111, code_reg, 8'h00};

  // State and output registers; reset aborts any frame in progress
  always_ff @(posedge clk100mhz) begin
    if (rst) begin
      state_reg    <= S_IDLE;
      shreg_reg    <= '0;
      code_reg     <= '0;
      cnt_reg      <= '0;
      bit_reg      <= '0;
      ref_done_reg <= 1'b0;
      is_ref_reg   <= 1'b0;
      cs_reg       <= 1'b1;
      sclk_reg     <= 1'b0;
      mosi_reg     <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      shreg_reg    <= shreg_next;
      code_reg     <= code_next;
      cnt_reg      <= cnt_next;
      bit_reg      <= bit_next;
      ref_done_reg <= ref_done_next;
      is_ref_reg   <= is_ref_next;
      cs_reg       <= cs_next;
      sclk_reg     <= sclk_next;
      mosi_reg     <= mosi_next;
      done_reg     <= done_next;
    end
  end

  // Next-state and next-output logic for the frame sequencer
  always_comb begin
    state_next    = state_reg;
    shreg_next    = shreg_reg;
    code_next     = code_reg;
    cnt_next      = cnt_reg;
    bit_next      = bit_reg;
    ref_done_next = ref_done_reg;
    is_ref_next   = is_ref_reg;
    cs_next       = cs_reg;
    sclk_next     = sclk_reg;
    mosi_next     = mosi_reg;
    done_next     = 1'b0;

    case (state_reg)
      S_IDLE: begin
        if (st_wrt) begin
          code_next  = data_in;
          state_next = ref_done_reg ? S_LOAD_DATA : S_LOAD_REF;
        end
      end

      S_LOAD_REF: begin
        shreg_next  = REF_FRAME;
        mosi_next   = REF_FRAME[31];
        is_ref_next = 1'b1;
        cs_next     = 1'b0;
        sclk_next   = 1'b0;
        cnt_next    = '0;
        bit_next    = '0;
        state_next  = S_SHIFT;
      end

      S_LOAD_DATA: begin
        shreg_next  = data_frame;
        mosi_next   = data_frame[31];
        is_ref_next = 1'b0;
        cs_next     = 1'b0;
        sclk_next   = 1'b0;
        cnt_next    = '0;
        bit_next    = '0;
        state_next  = S_SHIFT;
      end

      S_SHIFT: begin
        if (cnt_reg == HALF_M1) begin
          cnt_next = '0;
          if (!sclk_reg) begin
            sclk_next = 1'b1;
          end else begin
            // Falling edge: the DAC samples here, data moves on at the same edge
            sclk_next  = 1'b0;
            shreg_next = {shreg_reg[30:0], 1'b0};
            mosi_next  = shreg_reg[30];
            bit_next   = bit_reg + 5'd1;
            if (bit_reg == 5'd31) begin
              mosi_next  = 1'b0;
              state_next = S_TAIL;
            end
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end

      S_TAIL: begin
        // Hold cs low one more half-period after the last falling edge
        if (cnt_reg == HALF_M1) begin
          cnt_next   = '0;
          cs_next    = 1'b1;
          done_next  = !is_ref_reg;
          state_next = S_GAP;
          if (is_ref_reg) begin
            ref_done_next = 1'b1;
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end

      S_GAP: begin
        if (cnt_reg == GAP_M2) begin
          cnt_next   = '0;
          state_next = is_ref_reg ? S_LOAD_DATA : S_IDLE;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  assign cs   = cs_reg;
  assign sclk = sclk_reg;
  assign mosi = mosi_reg;
  assign done = done_reg;

endmodule

// File: tb/tb_top.sv
// Bench for the PMOD DA4 SPI master: a bus-level monitor decodes every
// cs-low window, checks its timing and compares the decoded word and the
// done pulse against a queue of expected frames filled by the stimulus.
module tb_top;

  localparam int H   = 10;
  localparam int GAP = 20;
  localparam logic [31:0] REF_W = 32'h0800_0001;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        st_wrt = 1'b0;
  logic [11:0] data_in = 12'h000;
  logic        cs, mosi, sclk, done;

  int tests = 0;
  int errors = 0;

  logic [31:0] exp_q[$];
  logic [31:0] log_q[$];
  int          frames_cnt = 0;
  int          done_cnt = 0;

  top #(.SCLK_HALF(H), .GAP_CYCLES(GAP)) dut (
    .clk100mhz(clk), .rst(rst), .cs(cs), .mosi(mosi), .sclk(sclk),
    .st_wrt(st_wrt), .data_in(data_in), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] data_word(input logic [11:0] c);
    return {8'h03, 4'hF, c, 8'h00};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Bus monitor: decode and time every frame from the pins alone
  logic        prev_cs = 1'b1, prev_sclk = 1'b0, prev_mosi = 1'b0;
  logic        in_frame = 1'b0;
  int          low_cnt = 0, high_cnt = 1000, fall_cnt = 0, last_rise = 0, rise_cnt = 0;
  logic [31:0] bits = '0;
  logic [31:0] exp_w;
  logic        exp_done;

  always @(negedge clk) begin
    if (rst) begin
      in_frame  = 1'b0;
      prev_cs   = 1'b1;
      prev_sclk = 1'b0;
      prev_mosi = 1'b0;
      high_cnt  = 1000;
    end else begin
      exp_done = 1'b0;
      if (cs === 1'b1) check("sclk_idle_low", {31'b0, sclk}, 32'd0);
      if (prev_cs && !cs) begin
        check("gap_min", {31'b0, high_cnt >= GAP}, 32'd1);
        in_frame = 1'b1;
        low_cnt  = 0;
        fall_cnt = 0;
        rise_cnt = 0;
        bits     = '0;
      end
      if (!cs && in_frame) begin
        low_cnt++;
        if (!prev_sclk && sclk) begin
          if (rise_cnt == 0) check("first_rise", low_cnt, H + 1);
          else               check("sclk_period", low_cnt - last_rise, 2 * H);
          last_rise = low_cnt;
          rise_cnt++;
        end
        if (prev_sclk && !sclk) begin
          bits = {bits[30:0], prev_mosi};
          fall_cnt++;
        end
      end
      if (!prev_cs && cs && in_frame) begin
        check("cs_low_cycles", low_cnt, 65 * H);
        check("fall_edges", fall_cnt, 32);
        if (exp_q.size() == 0) begin
          tests++;
          errors++;
          $display("FAIL frame_unexpected: got %h, expected no frame", bits);
        end else begin
          exp_w = exp_q.pop_front();
          check("frame_word", bits, exp_w);
          exp_done = (exp_w != REF_W);
        end
        log_q.push_back(bits);
        frames_cnt++;
        in_frame = 1'b0;
        high_cnt = 0;
      end
      if (cs) high_cnt++;
      check("done_pulse", {31'b0, done}, {31'b0, exp_done});
      if (done) done_cnt++;
      $display("[TB] t=%0t cs=%b sclk=%b mosi=%b done=%b", $time, cs, sclk, mosi, done);
      prev_cs   = cs;
      prev_sclk = sclk;
      prev_mosi = mosi;
    end
  end

  task automatic wait_frames(input int target);
    int n = 0;
    while (frames_cnt < target && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    check("wait_frames_timeout", {31'b0, frames_cnt >= target}, 32'd1);
  endtask

  task automatic wait_cs_low();
    int n = 0;
    while (cs !== 1'b0 && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
    check("wait_cs_low_timeout", {31'b0, cs}, 32'd0);
  endtask

  task automatic check_idle_pins(input string name);
    check({name, "_cs"},   {31'b0, cs},   32'd1);
    check({name, "_sclk"}, {31'b0, sclk}, 32'd0);
    check({name, "_mosi"}, {31'b0, mosi}, 32'd0);
    check({name, "_done"}, {31'b0, done}, 32'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_idle_pins("reset");

    // No request: bus stays idle
    repeat (200) @(posedge clk);
    #1;
    check("idle_no_frames", frames_cnt, 0);
    check_idle_pins("idle");

    // Level request held: REF, then data frames following data_in changes
    exp_q.push_back(REF_W);
    exp_q.push_back(data_word(12'hCB5));
    exp_q.push_back(data_word(12'h000));
    exp_q.push_back(data_word(12'hFFF));
    exp_q.push_back(data_word(12'h001));
    st_wrt  = 1'b1;
    data_in = 12'hCB5;
    wait_frames(1);
    wait_cs_low(); repeat (50) @(posedge clk); #1 data_in = 12'h000;
    wait_frames(2);
    wait_cs_low(); repeat (50) @(posedge clk); #1 data_in = 12'hFFF;
    wait_frames(3);
    wait_cs_low(); repeat (50) @(posedge clk); #1 data_in = 12'h001;
    wait_frames(4);
    wait_cs_low(); repeat (50) @(posedge clk); #1 st_wrt = 1'b0;
    wait_frames(5);
    repeat (300) @(posedge clk);
    #1;
    check("lit_ref",    log_q[0], 32'h0800_0001);
    check("lit_cb5",    log_q[1], 32'h03FC_B500);
    check("lit_000",    log_q[2], 32'h03F0_0000);
    check("lit_fff",    log_q[3], 32'h03FF_FF00);
    check("lit_001",    log_q[4], 32'h03F0_0100);
    check("done_count", done_cnt, 4);
    check("stop_frames", frames_cnt, 5);
    check_idle_pins("stopped");

    // Reset in the middle of a data frame (around bit 15)
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    exp_q.push_back(REF_W);
    exp_q.push_back(data_word(12'h5A5));
    st_wrt  = 1'b1;
    data_in = 12'h5A5;
    wait_frames(6);
    st_wrt = 1'b0;
    wait_cs_low();
    repeat (15 * 2 * H + H / 2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    check_idle_pins("mid_reset");
    exp_q.delete();

    // After reset the reference frame must be sent again
    exp_q.push_back(REF_W);
    exp_q.push_back(data_word(12'h3C3));
    st_wrt  = 1'b1;
    data_in = 12'h3C3;
    wait_frames(7);
    wait_cs_low(); repeat (20) @(posedge clk); #1 st_wrt = 1'b0;
    wait_frames(8);
    repeat (100) @(posedge clk);
    #1;
    check("lit_ref_again", log_q[6], 32'h0800_0001);
    check("lit_3c3",       log_q[7], 32'h03F3_C300);
    check("done_count_2",  done_cnt, 5);
    check("exp_q_empty",   exp_q.size(), 0);
    check_idle_pins("final");

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
